usb_data_buffer: RTL

//  Byte FIFO between usb_rx and the host interface; it also carries the TX payload path.
//  - usb_rx pushes payload bytes via rx_store_packet_data/rx_packet_data; the host pops them.
//  - The host pushes TX bytes; the TX encoder pops them.
//  - Exports buffer_occupancy, which usb_rx and the protocol FSM read. Single shared storage.

---
 rtl/usb_pkg.sv | 8 +
 rtl/usb_buffer_ram.sv | 26 ++
 rtl/usb_data_buffer.sv | 90 +++++++++
 3 files changed

// File: rtl/usb_pkg.sv
// Shared USB definitions: buffer geometry and the common byte type.
package usb_pkg;

    localparam int unsigned BUFFER_DEPTH = 64;

    typedef logic [7:0] usb_byte_t;

endpackage

// File: rtl/usb_buffer_ram.sv
// Byte storage for the USB data buffer: one synchronous write port, async read.
module usb_buffer_ram #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned DATA_W = 8,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/usb_data_buffer.sv
// Shared byte FIFO between usb_rx/host (RX payload) and host/TX encoder (TX payload).
module usb_data_buffer
    import usb_pkg::*;
#(
    parameter int unsigned DEPTH  = BUFFER_DEPTH,
    parameter int unsigned DATA_W = $bits(usb_byte_t),
    localparam int unsigned OCC_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              rx_store_packet_data,
    input  logic [DATA_W-1:0] rx_packet_data,
    input  logic              store_tx_data,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              get_rx_data,
    output logic [DATA_W-1:0] rx_data,
    input  logic              get_tx_packet_data,
    output logic [DATA_W-1:0] tx_packet_data,
    input  logic              flush,
    output logic [OCC_W-1:0]  buffer_occupancy
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [OCC_W-1:0]  occ;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              full;
    logic              empty;
    logic              push_ok;
    logic              pop_ok;
    logic              ram_we;

    // Full/empty come from the occupancy count only; rx wins both arbitrations.
    assign full    = (occ == OCC_W'(DEPTH));
    assign empty   = (occ == '0);
    assign push_ok = (rx_store_packet_data | store_tx_data) & ~full;
    assign pop_ok  = (get_rx_data | get_tx_packet_data) & ~empty;
    assign wr_data = rx_store_packet_data ? rx_packet_data : tx_data;
    assign ram_we  = push_ok & ~flush;

    usb_buffer_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wptr),
        .wdata (wr_data),
        .raddr (rptr),
        .rdata (rd_data)
    );

    // Pointer, occupancy and output-register update; flush overrides everything.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr           <= '0;
            rptr           <= '0;
            occ            <= '0;
            rx_data        <= '0;
            tx_packet_data <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + AW'(1);
            end
            if (pop_ok) begin
                rptr <= rptr + AW'(1);
                if (get_rx_data) begin
                    rx_data <= rd_data;
                end else begin
                    tx_packet_data <= rd_data;
                end
            end
            case ({push_ok, pop_ok})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    assign buffer_occupancy = occ;

endmodule
